sga_render_sequencer: RTL and testbench
=======================================

# sga_render_sequencer

Sequences one render pass of the Snake Game Arcade board. On a start pulse from the control unit's render state, it walks the snake body position memory segment by segment and plots each segment into a private shadow bitmap. It then overlays the apple, commits the completed frame to the display bitmap in one cycle, and pulses `render_done`, which feeds the control unit's `render_finish` input. It can also report head-to-body collision for the control unit's `is_at_body` input.

## Interface
- `MAX_SIZE`, 16: maximum number of snake segments held in body memory.
- `ADDR_W`, 4: body memory address width; must satisfy 2^ADDR_W ≥ MAX_SIZE.
- `COORD_W`, 3: coordinate width. Board is BOARD_W = 2^COORD_W squares per side.

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `restart_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle request to begin a render pass; sampled only in IDLE.
- `size`  in  ADDR_W+1  current snake length; sampled with `start`.
- `apple_x`, `apple_y`  in  COORD_W each  apple position; sampled with `start`.
- `seg_addr`  out  ADDR_W  body memory read address; segment 0 is the head.
- `seg_x`, `seg_y`  in  COORD_W each  body memory read data; valid one cycle after `seg_addr`.
- `frame`  out  BOARD_W*BOARD_W  committed bitmap; bit index is y*BOARD_W + x.
- `busy`  out  1  high from the cycle after `start` is accepted until `render_done` is high, inclusive.
- `render_done`  out  1  one-cycle pulse when `frame` holds the new pass.
- `is_at_body`  out  1  head shares a square with another segment (see Configuration).
- `db_state`  out  3  current state encoding, for debug displays.

## Operation
States and encoding: IDLE=0, CLEAR=1, FETCH=2, PLOT=3, APPLE=4, DONE=5. Unused encodings go to IDLE.

- **IDLE**
  - If `start`=1: latch n = min(`size`, MAX_SIZE), latch apple coordinates, then go to CLEAR.
  - Otherwise remain in IDLE.
- **CLEAR**
  - Shadow bitmap <= 0; segment index <= 0; `is_at_body` <= 0.
  - If n=0, go to APPLE; otherwise go to FETCH.
- **FETCH**
  - Drive `seg_addr` = index; go to PLOT.
- **PLOT**
  - Set shadow bit at (`seg_x`, `seg_y`).
  - If index=0, latch head coordinates.
  - If index≥1 and the segment equals the head, set `is_at_body`.
  - If index = n−1, go to APPLE; otherwise increment index and go to FETCH.
- **APPLE**
  - `frame` <= shadow OR apple bit; go to DONE.
- **DONE**
  - `render_done`=1; go to IDLE.

Rules:
- Plotting is a bitwise OR. A duplicate segment, or the apple sitting on the body, sets the bit once with no error.
- `seg_addr` holds its last driven value outside FETCH.
- `size`, `apple_x` and `apple_y` may change during a pass without effect, because they are latched at `start`.

## Timing
- Reset, with `restart_n`=0 at a rising edge, sets:
  - state to IDLE,
  - `frame`, the shadow bitmap, the segment index and `seg_addr` to 0,
  - `busy`, `render_done` and `is_at_body` to 0.
- Reset mid-pass aborts the pass: no `render_done` is issued and `frame` is cleared.
- `start` accepted at edge k gives:
  - CLEAR in cycle k+1,
  - FETCH/PLOT pairs in cycles k+2 through k+2n+1,
  - APPLE in cycle k+2n+2,
  - DONE in cycle k+2n+3.
- `render_done` is high for exactly cycle k+2n+3 (k+3 when n=0). `frame` is new from that same cycle.
- `frame` never shows a partially plotted board; it changes only on the APPLE→DONE edge or on reset.
- `start` while `busy`=1 is ignored and is not queued. `start` in the DONE cycle is also ignored.
- Back-to-back passes: the earliest next accepted `start` is in the cycle after DONE.
- `is_at_body` is valid from DONE until the next CLEAR.

## Configuration
- `SGA_RENDER_COLLISION_EN` defined:
  - head coordinate latch and comparator are built;
  - `is_at_body` behaves as described in Operation.
- `SGA_RENDER_COLLISION_EN` undefined:
  - no comparator or head latch is built;
  - `is_at_body` is constant 0;
  - all other behaviour and timing are identical.

## Test plan
- **Reset:** hold `restart_n`=0 for 2 cycles with `start`=1 → state 0, `frame`=0, `busy`=0, `render_done` never 1.
- **Three-segment pass:** `size`=3, segments (2,3),(2,4),(2,5), apple (6,1) → `render_done` at k+9; `frame` bits 26, 34, 42 and 14 set, all others 0; `is_at_body`=0.
- **Empty snake:** `size`=0, apple (0,0) → `render_done` at k+3; `frame`=1; `seg_addr` stays 0.
- **Collision:** `size`=5 with segment 4 equal to head (3,3) → `is_at_body`=1 at DONE with the macro defined, 0 without it. `frame` is identical in both builds.
- **Ignored start and clamping:**
  - Pulse `start` mid-pass → exactly one `render_done`, and the latched `size` is unchanged.
  - `size`=31 with MAX_SIZE=16 → 16 FETCH cycles, `seg_addr` sequence 0..15.
- **Reset mid-pass:** `restart_n`=0 during PLOT of segment 2 → IDLE next cycle, `frame`=0, and no `render_done` follows.

Source files
------------

// File: rtl/sga_render_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sga_render_sequencer
// Description : Renders one Snake Game Arcade frame per start pulse. Walks
//               the snake body memory segment by segment, plots each segment
//               into a private shadow bitmap, overlays the apple, then commits
//               the finished bitmap to 'frame' in a single cycle and pulses
//               'render_done'. Optionally reports head-to-body collision.
// Optional    : SGA_RENDER_COLLISION_EN builds the head latch and comparator
//               behind 'is_at_body'; when undefined 'is_at_body' is tied 0.
// Ports       : clock, restart_n (sync active-low reset)
//               start, size, apple_x, apple_y    - pass request + parameters
//               seg_addr -> / seg_x, seg_y <-    - body memory read port
//               frame                            - committed bitmap (y*W+x)
//               busy, render_done, is_at_body    - status to control unit
//               db_state                         - state code for debug
// Revision    : 1.0 - initial release
// ============================================================================
module sga_render_sequencer #(
  parameter int MAX_SIZE = 16,
  parameter int ADDR_W   = 4,
  parameter int COORD_W  = 3
) (
  input  logic                          clock,
  input  logic                          restart_n,
  input  logic                          start,
  input  logic [ADDR_W:0]               size,
  input  logic [COORD_W-1:0]            apple_x,
  input  logic [COORD_W-1:0]            apple_y,
  output logic [ADDR_W-1:0]             seg_addr,
  input  logic [COORD_W-1:0]            seg_x,
  input  logic [COORD_W-1:0]            seg_y,
  output logic [(2**(2*COORD_W))-1:0]   frame,
  output logic                          busy,
  output logic                          render_done,
  output logic                          is_at_body,
  output logic [2:0]                    db_state
);

  localparam int BOARD_W = 2**COORD_W;
  localparam int FRAME_W = BOARD_W * BOARD_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_PLOT  = 3'd3;
  localparam logic [2:0] S_APPLE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [ADDR_W:0]    MAX_N   = (ADDR_W+1)'(MAX_SIZE);
  localparam logic [ADDR_W:0]    N_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0]  IDX_ONE = ADDR_W'(1);
  localparam logic [FRAME_W-1:0] BIT0    = FRAME_W'(1);

  logic [2:0]           state_q,    state_d;
  logic [ADDR_W:0]      n_q,        n_d;
  logic [COORD_W-1:0]   apple_x_q,  apple_x_d;
  logic [COORD_W-1:0]   apple_y_q,  apple_y_d;
  logic [ADDR_W-1:0]    idx_q,      idx_d;
  logic [ADDR_W-1:0]    seg_addr_q, seg_addr_d;
  logic [FRAME_W-1:0]   shadow_q,   shadow_d;
  logic [FRAME_W-1:0]   frame_q,    frame_d;

`ifdef SGA_RENDER_COLLISION_EN
  logic [COORD_W-1:0]   head_x_q,   head_x_d;
  logic [COORD_W-1:0]   head_y_q,   head_y_d;
  logic                 body_q,     body_d;
`endif

  logic [FRAME_W-1:0]   seg_bit;
  logic [FRAME_W-1:0]   apple_bit;
  logic                 last_seg;

  // {y, x} concatenated is exactly y*BOARD_W + x because BOARD_W is 2^COORD_W.
  assign seg_bit   = BIT0 << {seg_y, seg_x};
  assign apple_bit = BIT0 << {apple_y_q, apple_x_q};
  // Only evaluated in PLOT, where n_q is at least 1.
  assign last_seg  = ({1'b0, idx_q} == (n_q - N_ONE));

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    apple_x_d  = apple_x_q;
    apple_y_d  = apple_y_q;
    idx_d      = idx_q;
    seg_addr_d = seg_addr_q;
    shadow_d   = shadow_q;
    frame_d    = frame_q;
`ifdef SGA_RENDER_COLLISION_EN
    head_x_d   = head_x_q;
    head_y_d   = head_y_q;
    body_d     = body_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d       = (size > MAX_N) ? MAX_N : size;
          apple_x_d = apple_x;
          apple_y_d = apple_y;
          state_d   = S_CLEAR;
        end
      end

      S_CLEAR: begin
        shadow_d = '0;
        idx_d    = '0;
`ifdef SGA_RENDER_COLLISION_EN
        body_d   = 1'b0;
`endif
        if (n_q == '0) begin
          state_d = S_APPLE;
        end else begin
          // Address is registered so it is stable for the whole FETCH cycle;
          // an empty snake never touches it.
          seg_addr_d = '0;
          state_d    = S_FETCH;
        end
      end

      S_FETCH: begin
        state_d = S_PLOT;
      end

      S_PLOT: begin
        shadow_d = shadow_q | seg_bit;
`ifdef SGA_RENDER_COLLISION_EN
        if (idx_q == '0) begin
          head_x_d = seg_x;
          head_y_d = seg_y;
        end else if ((seg_x == head_x_q) && (seg_y == head_y_q)) begin
          body_d = 1'b1;
        end
`endif
        if (last_seg) begin
          state_d = S_APPLE;
        end else begin
          idx_d      = idx_q + IDX_ONE;
          seg_addr_d = idx_q + IDX_ONE;
          state_d    = S_FETCH;
        end
      end

      S_APPLE: begin
        // Single-cycle commit: the display never sees a half-drawn board.
        frame_d = shadow_q | apple_bit;
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!restart_n) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      apple_x_q  <= '0;
      apple_y_q  <= '0;
      idx_q      <= '0;
      seg_addr_q <= '0;
      shadow_q   <= '0;
      frame_q    <= '0;
`ifdef SGA_RENDER_COLLISION_EN
      head_x_q   <= '0;
      head_y_q   <= '0;
      body_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      apple_x_q  <= apple_x_d;
      apple_y_q  <= apple_y_d;
      idx_q      <= idx_d;
      seg_addr_q <= seg_addr_d;
      shadow_q   <= shadow_d;
      frame_q    <= frame_d;
`ifdef SGA_RENDER_COLLISION_EN
      head_x_q   <= head_x_d;
      head_y_q   <= head_y_d;
      body_q     <= body_d;
`endif
    end
  end

  assign seg_addr    = seg_addr_q;
  assign frame       = frame_q;
  assign busy        = (state_q != S_IDLE);
  assign render_done = (state_q == S_DONE);
  assign db_state    = state_q;

`ifdef SGA_RENDER_COLLISION_EN
  assign is_at_body  = body_q;
`else
  assign is_at_body  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sga_render_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sga_render_sequencer
// Description : Self-checking bench for sga_render_sequencer. A synchronous
//               body memory model answers seg_addr; each pass is predicted
//               from the board rules (OR of the first min(size,16) segments
//               plus the apple, latency 2n+3, head-repeat collision).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sga_render_sequencer;

  localparam int MAX_SIZE = 16;
  localparam int ADDR_W   = 4;
  localparam int COORD_W  = 3;

  logic        clock;
  logic        restart_n;
  logic        start;
  logic [4:0]  size;
  logic [2:0]  apple_x, apple_y;
  logic [3:0]  seg_addr;
  logic [2:0]  seg_x, seg_y;
  logic [63:0] frame;
  logic        busy, render_done, is_at_body;
  logic [2:0]  db_state;

  int compared   = 0;
  int mismatched = 0;
  int done_count = 0;
  int passes_done = 0;
  int fetch_q[$];

  logic [2:0] mem_x [16];
  logic [2:0] mem_y [16];

  sga_render_sequencer #(
    .MAX_SIZE(MAX_SIZE), .ADDR_W(ADDR_W), .COORD_W(COORD_W)
  ) dut (
    .clock(clock), .restart_n(restart_n), .start(start), .size(size),
    .apple_x(apple_x), .apple_y(apple_y), .seg_addr(seg_addr),
    .seg_x(seg_x), .seg_y(seg_y), .frame(frame), .busy(busy),
    .render_done(render_done), .is_at_body(is_at_body), .db_state(db_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Body memory: registered read, data one cycle after the address.
  always @(posedge clock) begin
    seg_x <= mem_x[seg_addr];
    seg_y <= mem_y[seg_addr];
  end

  // Passive monitor: addresses presented during FETCH, and done pulses.
  always @(negedge clock) begin
    if (db_state == 3'd2) fetch_q.push_back(int'(seg_addr));
    if (render_done === 1'b1) done_count++;
  end

  function automatic logic [63:0] model_frame(int n, int ax, int ay);
    logic [63:0] f;
    f = '0;
    for (int i = 0; i < n; i++) f[int'(mem_y[i]) * 8 + int'(mem_x[i])] = 1'b1;
    f[ay * 8 + ax] = 1'b1;
    return f;
  endfunction

  function automatic bit model_collision(int n);
    bit c;
    c = 1'b0;
`ifdef SGA_RENDER_COLLISION_EN
    for (int i = 1; i < n; i++)
      if (mem_x[i] == mem_x[0] && mem_y[i] == mem_y[0]) c = 1'b1;
`endif
    return c;
  endfunction

  task automatic fill_mem_random(input bit force_hit);
    int k;
    for (int i = 0; i < 16; i++) begin
      mem_x[i] = 3'($urandom);
      mem_y[i] = 3'($urandom);
    end
    if (force_hit) begin
      k = int'($urandom_range(1, 15));
      mem_x[k] = mem_x[0];
      mem_y[k] = mem_y[0];
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      start = 1'b0;
    end
  endtask

  // One render pass. glitch_cyc (>0) pulses start during the pass; done_glitch
  // pulses start in the DONE cycle. Returns at the DONE-cycle negedge so the
  // next pass can start in the very next cycle.
  task automatic run_pass(input int sz, input int ax, input int ay,
                          input int glitch_cyc, input bit done_glitch);
    int n, cyc, exp_lat;
    logic [63:0] exp_f, frame_before;
    bit exp_col, seen, stable, busy_ok, order_ok;
    logic [2:0] st1;

    @(negedge clock);
    compared++;
    if (db_state !== 3'd0 || busy !== 1'b0 || render_done !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_before_start: state=%0d busy=%b done=%b, required 0/0/0",
               db_state, busy, render_done);
    end
    compared++;
    if (done_count !== passes_done) begin
      mismatched++;
      $display("FAIL done_pulse_count: got %0d pulses, required %0d", done_count, passes_done);
    end

    n       = (sz > MAX_SIZE) ? MAX_SIZE : sz;
    exp_lat = 2 * n + 3;
    exp_f   = model_frame(n, ax, ay);
    exp_col = model_collision(n);
    fetch_q.delete();
    frame_before = frame;

    start   = 1'b1;
    size    = 5'(sz);
    apple_x = 3'(ax);
    apple_y = 3'(ay);

    cyc = 0; seen = 1'b0; stable = 1'b1; busy_ok = 1'b1; st1 = 3'd7;
    while (!seen && cyc < 100) begin
      @(negedge clock);
      cyc++;
      // Latched inputs: scramble them for the rest of the pass.
      start   = (cyc == glitch_cyc);
      size    = 5'($urandom);
      apple_x = 3'($urandom);
      apple_y = 3'($urandom);
      if (cyc == 1) st1 = db_state;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (render_done === 1'b1) seen = 1'b1;
      else if (frame !== frame_before) stable = 1'b0;
    end
    start = done_glitch;
    if (seen) passes_done++;

    compared++;
    if (st1 !== 3'd1) begin
      mismatched++;
      $display("FAIL clear_after_start: state=%0d, required 1", st1);
    end
    compared++;
    if (!seen || cyc != exp_lat) begin
      mismatched++;
      $display("FAIL done_latency: seen=%0d at cycle %0d, required cycle %0d", seen, cyc, exp_lat);
    end
    compared++;
    if (frame !== exp_f) begin
      mismatched++;
      $display("FAIL frame_value: got %h, required %h (size=%0d)", frame, exp_f, sz);
    end
    compared++;
    if (is_at_body !== exp_col) begin
      mismatched++;
      $display("FAIL is_at_body: got %b, required %b", is_at_body, exp_col);
    end
    compared++;
    if (!stable || !busy_ok) begin
      mismatched++;
      $display("FAIL pass_stability: frame_stable=%0d busy_held=%0d, required 1/1", stable, busy_ok);
    end
    order_ok = (fetch_q.size() == n);
    if (order_ok)
      for (int i = 0; i < n; i++) if (fetch_q[i] != i) order_ok = 1'b0;
    compared++;
    if (!order_ok) begin
      mismatched++;
      $display("FAIL fetch_sequence: %0d fetches, required %0d in order 0..n-1", fetch_q.size(), n);
    end
  endtask

  task automatic test_reset;
    bit saw_done;
    restart_n = 1'b0; start = 1'b1; size = 5'd3; apple_x = '0; apple_y = '0;
    saw_done = 1'b0;
    repeat (2) begin
      @(negedge clock);
      if (render_done === 1'b1) saw_done = 1'b1;
    end
    compared++;
    if (db_state !== 3'd0 || frame !== 64'd0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state: state=%0d frame=%h busy=%b, required 0/0/0", db_state, frame, busy);
    end
    compared++;
    if (saw_done || seg_addr !== 4'd0 || is_at_body !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: done_seen=%0d seg_addr=%0d body=%b, required 0/0/0",
               saw_done, seg_addr, is_at_body);
    end
    restart_n = 1'b1;
    start     = 1'b0;
  endtask

  task automatic test_empty_snake;
    run_pass(0, 0, 0, 0, 1'b0);
    compared++;
    if (seg_addr !== 4'd0) begin
      mismatched++;
      $display("FAIL empty_seg_addr: got %0d, required 0", seg_addr);
    end
  endtask

  task automatic test_three_segments;
    logic [63:0] exp_lit;
    mem_x[0] = 3'd2; mem_y[0] = 3'd3;
    mem_x[1] = 3'd2; mem_y[1] = 3'd4;
    mem_x[2] = 3'd2; mem_y[2] = 3'd5;
    run_pass(3, 6, 1, 0, 1'b0);
    exp_lit = '0;
    exp_lit[26] = 1'b1; exp_lit[34] = 1'b1; exp_lit[42] = 1'b1; exp_lit[14] = 1'b1;
    compared++;
    if (frame !== exp_lit) begin
      mismatched++;
      $display("FAIL three_seg_bits: got %h, required %h", frame, exp_lit);
    end
  endtask

  task automatic test_collision;
    mem_x[0] = 3'd3; mem_y[0] = 3'd3;
    mem_x[1] = 3'd3; mem_y[1] = 3'd4;
    mem_x[2] = 3'd4; mem_y[2] = 3'd4;
    mem_x[3] = 3'd4; mem_y[3] = 3'd3;
    mem_x[4] = 3'd3; mem_y[4] = 3'd3;
    run_pass(5, 0, 7, 0, 1'b0);
  endtask

  task automatic test_ignored_start;
    fill_mem_random(1'b0);
    run_pass(4, 5, 5, 3, 1'b1);
    run_pass(2, 1, 6, 0, 1'b0);
  endtask

  task automatic test_clamp;
    fill_mem_random(1'b0);
    run_pass(31, 7, 7, 0, 1'b0);
    compared++;
    if (fetch_q.size() != MAX_SIZE) begin
      mismatched++;
      $display("FAIL clamp_fetch_count: got %0d, required %0d", fetch_q.size(), MAX_SIZE);
    end
  endtask

  task automatic test_back_to_back;
    for (int p = 0; p < 3; p++) begin
      fill_mem_random(p[0]);
      run_pass(int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), 0, 1'b0);
    end
  endtask

  task automatic test_random;
    int sz, g;
    for (int p = 0; p < 15; p++) begin
      fill_mem_random($urandom_range(0, 1) == 1);
      sz = int'($urandom_range(0, 31));
      g  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
      run_pass(sz, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               g, $urandom_range(0, 3) == 0);
      idle(int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_reset_mid_pass;
    int cyc;
    idle(2);
    fill_mem_random(1'b0);
    @(negedge clock);
    start = 1'b1; size = 5'd5; apple_x = 3'd1; apple_y = 3'd1;
    cyc = 0;
    while (cyc < 7) begin
      @(negedge clock);
      cyc++;
      start = 1'b0;
    end
    compared++;
    if (db_state !== 3'd3) begin
      mismatched++;
      $display("FAIL mid_pass_plot: state=%0d at seg 2 plot, required 3", db_state);
    end
    restart_n = 1'b0;
    @(negedge clock);
    restart_n = 1'b1;
    compared++;
    if (db_state !== 3'd0 || frame !== 64'd0 || busy !== 1'b0 || seg_addr !== 4'd0) begin
      mismatched++;
      $display("FAIL mid_pass_reset: state=%0d frame=%h busy=%b addr=%0d, required 0/0/0/0",
               db_state, frame, busy, seg_addr);
    end
    idle(40);
    compared++;
    if (done_count !== passes_done) begin
      mismatched++;
      $display("FAIL mid_pass_no_done: got %0d pulses, required %0d", done_count, passes_done);
    end
  endtask

  initial begin
    restart_n = 1'b0; start = 1'b0; size = '0; apple_x = '0; apple_y = '0;
    for (int i = 0; i < 16; i++) begin mem_x[i] = '0; mem_y[i] = '0; end
    test_reset();
    test_empty_snake();
    test_three_segments();
    test_collision();
    test_ignored_start();
    test_clamp();
    test_back_to_back();
    test_random();
    test_reset_mid_pass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
